// File: rtl/axi_lite_lfsr_seed_ctrl.sv
// Serial seed-load / peek controller for the AXI4-Lite LFSR subordinate.
// Shifts DataWidth bits LSB-first and captures the state shifted out.
module axi_lite_lfsr_seed_ctrl #(
    parameter int DataWidth = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 cmd_valid_i,
    output logic                 cmd_ready_o,
    input  logic [1:0]           cmd_target_i,
    input  logic                 cmd_peek_i,
    input  logic [DataWidth-1:0] cmd_seed_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [DataWidth-1:0] rsp_state_o,
    output logic                 w_ser_en_o,
    output logic                 w_ser_data_o,
    input  logic                 w_ser_data_i,
    output logic                 r_ser_en_o,
    output logic                 r_ser_data_o,
    input  logic                 r_ser_data_i,
    input  logic                 r_ready_i
);
    localparam int KW = $clog2(DataWidth);
    localparam logic [KW-1:0] KLast = KW'(DataWidth - 1);

    typedef enum logic [1:0] {
        IDLE,
        RWAIT,
        SHIFT,
        DONE
    } state_e;

    state_e               r_state;
    state_e               w_next;
    logic [1:0]           r_tgt;
    logic                 r_peek;
    logic [DataWidth-1:0] r_seed;
    logic [DataWidth-1:0] r_cap;
    logic [KW-1:0]        r_k;
    logic                 w_accept;
    logic                 w_last;
    logic                 w_sel_in;
    logic                 w_seed_bit;

    assign w_accept   = cmd_valid_i & (r_state == IDLE);
    assign w_last     = (r_k == KLast);
    // The W side is reported whenever it is selected.
    assign w_sel_in   = r_tgt[0] ? w_ser_data_i : r_ser_data_i;
    assign w_seed_bit = r_seed[r_k];

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; an R target waits for a completed R handshake
    // so that the LFSR's r_valid never drops while a beat is pending.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (cmd_valid_i) begin
                    if (cmd_target_i == 2'b00) begin
                        w_next = DONE;
                    end else if (cmd_target_i[1]) begin
                        w_next = RWAIT;
                    end else begin
                        w_next = SHIFT;
                    end
                end
            end
            RWAIT: begin
                if (r_ready_i) begin
                    w_next = SHIFT;
                end
            end
            SHIFT: begin
                if (w_last) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                if (rsp_ready_i) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Command capture, bit counter and capture of the shifted-out state
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_tgt  <= '0;
            r_peek <= 1'b0;
            r_seed <= '0;
            r_cap  <= '0;
            r_k    <= '0;
        end else if (w_accept) begin
            r_tgt  <= cmd_target_i;
            r_peek <= cmd_peek_i;
            r_seed <= cmd_seed_i;
            r_cap  <= '0;
            r_k    <= '0;
        end else if (r_state == SHIFT) begin
            r_cap  <= {w_sel_in, r_cap[DataWidth-1:1]};
            r_k    <= r_k + KW'(1);
        end
    end

    // Outputs decoded from registered state only; peek recirculates
    always_comb begin
        cmd_ready_o  = (r_state == IDLE);
        rsp_valid_o  = (r_state == DONE);
        rsp_state_o  = (r_state == DONE) ? r_cap : '0;
        w_ser_en_o   = 1'b0;
        w_ser_data_o = 1'b0;
        r_ser_en_o   = 1'b0;
        r_ser_data_o = 1'b0;
        if (r_state == SHIFT) begin
            w_ser_en_o   = r_tgt[0];
            r_ser_en_o   = r_tgt[1];
            w_ser_data_o = r_tgt[0] &
                           (r_peek ? w_ser_data_i : w_seed_bit);
            r_ser_data_o = r_tgt[1] &
                           (r_peek ? r_ser_data_i : w_seed_bit);
        end
    end
endmodule

// File: tb/tb_axi_lite_lfsr_seed_ctrl.sv
// Bench for axi_lite_lfsr_seed_ctrl: emulated serial LFSRs,
// table vectors, corner sequences and random commands vs a model.
module tb_axi_lite_lfsr_seed_ctrl;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_i;
    logic          cmd_valid_i;
    logic          cmd_ready_o;
    logic [1:0]    cmd_target_i;
    logic          cmd_peek_i;
    logic [DW-1:0] cmd_seed_i;
    logic          rsp_valid_o;
    logic          rsp_ready_i;
    logic [DW-1:0] rsp_state_o;
    logic          w_ser_en_o;
    logic          w_ser_data_o;
    logic          w_ser_data_i;
    logic          r_ser_en_o;
    logic          r_ser_data_o;
    logic          r_ser_data_i;
    logic          r_ready_i;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    axi_lite_lfsr_seed_ctrl #(.DataWidth(DW)) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .cmd_valid_i  (cmd_valid_i),
        .cmd_ready_o  (cmd_ready_o),
        .cmd_target_i (cmd_target_i),
        .cmd_peek_i   (cmd_peek_i),
        .cmd_seed_i   (cmd_seed_i),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_ready_i  (rsp_ready_i),
        .rsp_state_o  (rsp_state_o),
        .w_ser_en_o   (w_ser_en_o),
        .w_ser_data_o (w_ser_data_o),
        .w_ser_data_i (w_ser_data_i),
        .r_ser_en_o   (r_ser_en_o),
        .r_ser_data_o (r_ser_data_o),
        .r_ser_data_i (r_ser_data_i),
        .r_ready_i    (r_ready_i)
    );

    // Emulated LFSR serial ports: LSB shifts out, new bit enters MSB.
    logic          pre_en;
    logic [DW-1:0] pre_w;
    logic [DW-1:0] pre_r;
    logic [DW-1:0] lfsr_w;
    logic [DW-1:0] lfsr_r;

    always @(posedge clk) begin
        if (pre_en) begin
            lfsr_w <= pre_w;
            lfsr_r <= pre_r;
        end else begin
            if (w_ser_en_o) lfsr_w <= {w_ser_data_o, lfsr_w[DW-1:1]};
            if (r_ser_en_o) lfsr_r <= {r_ser_data_o, lfsr_r[DW-1:1]};
        end
    end

    assign w_ser_data_i = lfsr_w[0];
    assign r_ser_data_i = lfsr_r[0];

    // r_valid is !r_ser_en; it may only drop after a cycle with r_ready.
    logic pv_valid = 1'b1;
    int   rv_viol = 0;

    always @(posedge clk) begin
        #2;
        if (!rst_i && pv_valid && r_ser_en_o && !r_ready_i)
            rv_viol = rv_viol + 1;
        pv_valid = !r_ser_en_o;
    end

    task automatic chk(input string nm, input string it,
                       input logic [63:0] a, input logic [63:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s %s: got %0h want %0h", nm, it, a, e);
        end
    endtask

    // Results of the last command
    logic [DW-1:0] o_resp;
    int o_nw, o_nr, o_mis, o_rf, o_rdyc, o_rspc;
    int o_unst, o_rdyb, o_junk, o_to;

    task automatic do_cmd(input logic [1:0] t, input logic pk,
                          input logic [DW-1:0] sd,
                          input int rdly, input int bp);
        int c;
        logic [DW-1:0] hold;
        o_nw = 0; o_nr = 0; o_mis = 0; o_rf = 0; o_rdyc = 0;
        o_rspc = 0; o_unst = 0; o_rdyb = 0; o_junk = 0; o_to = 0;
        o_resp = '0;
        c = 0;
        while (!cmd_ready_o && c < 100) begin
            @(negedge clk);
            c++;
        end
        cmd_valid_i = 1'b1;
        cmd_target_i = t;
        cmd_peek_i = pk;
        cmd_seed_i = sd;
        @(negedge clk);
        cmd_valid_i = 1'b0;
        cmd_seed_i = $urandom;
        c = 1;
        while (!rsp_valid_o && c < 300) begin
            if (w_ser_en_o) o_nw++;
            if (r_ser_en_o) begin
                o_nr++;
                if (o_rf == 0) o_rf = c;
            end
            if (w_ser_en_o != r_ser_en_o) o_mis++;
            if ((!w_ser_en_o && w_ser_data_o) ||
                (!r_ser_en_o && r_ser_data_o)) o_junk++;
            if (t[1] && c > rdly) begin
                r_ready_i = 1'b1;
                if (o_rdyc == 0) o_rdyc = c;
            end
            @(negedge clk);
            c++;
        end
        if (!rsp_valid_o) begin
            o_to = 1;
            r_ready_i = 1'b0;
            return;
        end
        o_rspc = c;
        hold = rsp_state_o;
        for (int i = 0; i < bp; i++) begin
            if (!rsp_valid_o || rsp_state_o !== hold) o_unst++;
            if (cmd_ready_o) o_rdyb++;
            @(negedge clk);
        end
        if (!rsp_valid_o || rsp_state_o !== hold) o_unst++;
        if (cmd_ready_o) o_rdyb++;
        o_resp = rsp_state_o;
        rsp_ready_i = 1'b1;
        @(negedge clk);
        rsp_ready_i = 1'b0;
        r_ready_i = 1'b0;
        if (!cmd_ready_o || rsp_valid_o) o_rdyb++;
    endtask

    task automatic verify(input string nm, input logic [1:0] t,
                          input int rdly, input logic [DW-1:0] er,
                          input logic [DW-1:0] ew,
                          input logic [DW-1:0] erv);
        int ersp;
        ersp = (t == 2'b00) ? 1 : (t[1] ? rdly + DW + 2 : DW + 1);
        chk(nm, "timeout", 64'(o_to), 64'(0));
        chk(nm, "rsp", 64'(o_resp), 64'(er));
        chk(nm, "lfsr_w", 64'(lfsr_w), 64'(ew));
        chk(nm, "lfsr_r", 64'(lfsr_r), 64'(erv));
        chk(nm, "w_en_cnt", 64'(o_nw), 64'(t[0] ? DW : 0));
        chk(nm, "r_en_cnt", 64'(o_nr), 64'(t[1] ? DW : 0));
        chk(nm, "rsp_cycle", 64'(o_rspc), 64'(ersp));
        chk(nm, "idle_data", 64'(o_junk), 64'(0));
        chk(nm, "stable", 64'(o_unst), 64'(0));
        chk(nm, "ready", 64'(o_rdyb), 64'(0));
        if (t == 2'b11) chk(nm, "align", 64'(o_mis), 64'(0));
        if (t[1]) chk(nm, "r_lat", 64'(o_rf - o_rdyc), 64'(1));
    endtask

    typedef struct {
        logic [1:0]    tgt;
        logic          peek;
        logic [DW-1:0] seed;
        int            rdly;
        int            bp;
        logic [DW-1:0] e_rsp;
        logic [DW-1:0] e_w;
        logic [DW-1:0] e_r;
    } vec_t;

    vec_t tv[9];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        logic [1:0]    t;
        logic          pk;
        logic [DW-1:0] sd;
        logic [DW-1:0] mw;
        logic [DW-1:0] mr;
        logic [DW-1:0] er;
        int            rd;
        int            n;
        int            c;

        tv[0] = '{2'b01, 1'b0, 32'hDEADBEEF, 0, 0,
                  32'h12345678, 32'hDEADBEEF, 32'hA5A50F0F};
        tv[1] = '{2'b01, 1'b1, 32'h0, 0, 0,
                  32'hDEADBEEF, 32'hDEADBEEF, 32'hA5A50F0F};
        tv[2] = '{2'b10, 1'b1, 32'h0, 3, 0,
                  32'hA5A50F0F, 32'hDEADBEEF, 32'hA5A50F0F};
        tv[3] = '{2'b10, 1'b1, 32'h0, 0, 1,
                  32'hA5A50F0F, 32'hDEADBEEF, 32'hA5A50F0F};
        tv[4] = '{2'b11, 1'b0, 32'h00000001, 2, 0,
                  32'hDEADBEEF, 32'h00000001, 32'h00000001};
        tv[5] = '{2'b10, 1'b1, 32'h0, 1, 0,
                  32'h00000001, 32'h00000001, 32'h00000001};
        tv[6] = '{2'b00, 1'b0, 32'hFFFFFFFF, 0, 2,
                  32'h0, 32'h00000001, 32'h00000001};
        tv[7] = '{2'b10, 1'b0, 32'h13579BDF, 1, 0,
                  32'h00000001, 32'h00000001, 32'h13579BDF};
        tv[8] = '{2'b11, 1'b1, 32'h0, 0, 0,
                  32'h00000001, 32'h00000001, 32'h13579BDF};

        rst_i = 1'b1;
        cmd_valid_i = 1'b0;
        cmd_target_i = 2'b00;
        cmd_peek_i = 1'b0;
        cmd_seed_i = '0;
        rsp_ready_i = 1'b0;
        r_ready_i = 1'b0;
        pre_en = 1'b1;
        pre_w = 32'h12345678;
        pre_r = 32'hA5A50F0F;
        repeat (3) @(negedge clk);
        chk("reset", "ctrl",
            64'({cmd_ready_o, rsp_valid_o, w_ser_en_o,
                 w_ser_data_o, r_ser_en_o, r_ser_data_o}),
            64'(6'b100000));
        chk("reset", "rsp_state", 64'(rsp_state_o), 64'(0));
        rst_i = 1'b0;
        pre_en = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            do_cmd(tv[i].tgt, tv[i].peek, tv[i].seed,
                   tv[i].rdly, tv[i].bp);
            verify($sformatf("vec%0d", i), tv[i].tgt, tv[i].rdly,
                   tv[i].e_rsp, tv[i].e_w, tv[i].e_r);
        end

        // R target with r_ready low for 10 cycles
        do_cmd(2'b10, 1'b1, 32'h0, 10, 0);
        verify("rwait", 2'b10, 10, 32'h13579BDF,
               32'h00000001, 32'h13579BDF);
        chk("rwait", "first_en", 64'(o_rf), 64'(12));

        // Response back-pressure for 20 cycles
        do_cmd(2'b01, 1'b1, 32'h0, 0, 20);
        verify("bp", 2'b01, 0, 32'h00000001,
               32'h00000001, 32'h13579BDF);

        // Reset during W shift cycle 7
        c = 0;
        while (!cmd_ready_o && c < 100) begin
            @(negedge clk);
            c++;
        end
        cmd_valid_i = 1'b1;
        cmd_target_i = 2'b01;
        cmd_peek_i = 1'b0;
        cmd_seed_i = 32'h0F0F0F0F;
        @(negedge clk);
        cmd_valid_i = 1'b0;
        n = 0;
        c = 0;
        while (n < 7 && c < 100) begin
            if (w_ser_en_o) n++;
            if (n < 7) begin
                @(negedge clk);
                c++;
            end
        end
        chk("rst_mid", "reach", 64'(n), 64'(7));
        rst_i = 1'b1;
        @(negedge clk);
        chk("rst_mid", "ctrl",
            64'({cmd_ready_o, rsp_valid_o, w_ser_en_o,
                 w_ser_data_o, r_ser_en_o, r_ser_data_o}),
            64'(6'b100000));
        chk("rst_mid", "rsp_state", 64'(rsp_state_o), 64'(0));
        rst_i = 1'b0;
        @(negedge clk);
        do_cmd(2'b01, 1'b0, 32'hCAFEF00D, 0, 0);
        chk("reload", "timeout", 64'(o_to), 64'(0));
        chk("reload", "w_en_cnt", 64'(o_nw), 64'(DW));
        chk("reload", "lfsr_w", 64'(lfsr_w), 64'(32'hCAFEF00D));
        do_cmd(2'b01, 1'b1, 32'h0, 0, 0);
        verify("reload_peek", 2'b01, 0, 32'hCAFEF00D,
               32'hCAFEF00D, 32'h13579BDF);

        // Random commands against an abstract register-pair model
        mw = 32'hCAFEF00D;
        mr = 32'h13579BDF;
        for (int i = 0; i < 40; i++) begin
            t = 2'($urandom_range(0, 3));
            pk = 1'($urandom_range(0, 1));
            sd = $urandom;
            rd = $urandom_range(0, 4);
            er = t[0] ? mw : (t[1] ? mr : '0);
            if (!pk && t[0]) mw = sd;
            if (!pk && t[1]) mr = sd;
            do_cmd(t, pk, sd, rd, $urandom_range(0, 3));
            verify($sformatf("rnd%0d", i), t, rd, er, mw, mr);
        end

        chk("monitor", "r_valid_drop", 64'(rv_viol), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/axi_lite_lfsr_seed_ctrl.md
# axi_lite_lfsr_seed_ctrl

Serial seed controller for the AXI4-Lite LFSR subordinate. It takes word-wide seed-load and peek commands, drives the W- and/or R-side serial shift ports of the LFSR for exactly `DataWidth` cycles, and captures the LFSR state shifted out during that window. Peek commands recirculate the state, so reading it back does not disturb it. The block sits beside the LFSR subordinate and is driven by a configuration master or a test controller.

## Interface
- `DataWidth`, default 32: LFSR and seed width. Must match the LFSR (8…1024).
- `clk_i`  in  1  rising-edge clock.
- `rst_i`  in  1  reset, synchronous, active-high.
- `cmd_valid_i`  in  1  command valid.
- `cmd_ready_o`  out  1  command ready.
- `cmd_target_i`  in  2  bit0 selects the W LFSR, bit1 selects the R LFSR. `2'b00` is illegal.
- `cmd_peek_i`  in  1  0 = load seed, 1 = nondestructive read.
- `cmd_seed_i`  in  DataWidth  seed value; ignored when peeking.
- `rsp_valid_o`  out  1  captured old state is valid.
- `rsp_ready_i`  in  1  response accept.
- `rsp_state_o`  out  DataWidth  LFSR state before the command (W side if bit0 is set, else R side).
- `w_ser_en_o`, `w_ser_data_o`  out  1  to the LFSR `w_ser_en_i` / `w_ser_data_i`.
- `w_ser_data_i`  in  1  from the LFSR `w_ser_data_o`.
- `r_ser_en_o`, `r_ser_data_o`  out  1  to the LFSR `r_ser_en_i` / `r_ser_data_i`.
- `r_ser_data_i`  in  1  from the LFSR `r_ser_data_o`.
- `r_ready_i`  in  1  snoop of the AXI `r_ready` at the LFSR.

## Operation
- FSM states:
  - IDLE → SHIFT on accept when bit1 is clear.
  - IDLE → RWAIT on accept when bit1 is set.
  - RWAIT → SHIFT in the cycle after one in which `r_ready_i` = 1.
  - SHIFT → DONE after `DataWidth` shift cycles.
  - DONE → IDLE on `rsp_valid_o & rsp_ready_i`.
- `cmd_ready_o` = 1 only in IDLE. Accept = `cmd_valid_i & cmd_ready_o`.
- On accept, register the target, peek flag and seed, and clear the bit counter.
- **RWAIT purpose:** the LFSR's `r_valid` is the inverse of `r_ser_en`. Asserting `r_ser_en` is allowed only after a completed R handshake, so `r_valid` never drops while pending.
- **W side:** no wait needed; its ready signals may drop legally.
- **SHIFT:**
  - Counter `k` runs 0…DataWidth-1, width `$clog2(DataWidth)`.
  - `*_ser_en_o` = 1 for each selected side, 0 for the unselected side.
  - Load: `*_ser_data_o` = `seed_q[k]`.
  - Peek: `*_ser_data_o` = `*_ser_data_i` for that side (recirculation).
  - Each cycle, capture `cap <= {sel_ser_data_i, cap[DataWidth-1:1]}`. `sel` = W if bit0 is set, else R.
- **DONE:** `rsp_valid_o` = 1 and `rsp_state_o` = `cap`, held stable until accepted.
- Bits are shifted LSB-first. After DataWidth shifts the LFSR holds the seed (load) or its prior state (peek), and `cap` equals the prior state.
- Outputs are unused in non-SHIFT states: all `*_ser_en_o` = 0 and `*_ser_data_o` = 0.
- An illegal target `2'b00` is accepted and completes with no shift. It goes IDLE → DONE in 1 cycle with `rsp_state_o` = 0.
- **Side effect:** while `w_ser_en_o` = 1, the LFSR holds `aw_ready`, `ar_ready` and `w_ready` low. The controlling software accounts for this stall.

## Timing
- **Reset values:** `cmd_ready_o` = 1, `rsp_valid_o` = 0, `rsp_state_o` = 0, all `*_ser_en_o` = 0, all `*_ser_data_o` = 0; FSM in IDLE.
- **Accept at edge 0 (W only):**
  - `w_ser_en_o` is high in cycles 1…DataWidth.
  - `rsp_valid_o` rises in cycle DataWidth+1.
  - `cmd_ready_o` returns the cycle after the response handshake.
- **R target:** SHIFT begins in cycle j+1 if `r_ready_i` = 1 in cycle j ≥ 1 (RWAIT). There is no timeout.
- **Both sides:** both enables assert in identical cycles. Entry into SHIFT is gated by RWAIT.
- **Back-pressure:** a stalled `rsp_ready_i` holds DONE. No new command is accepted until the response is taken.
- **Reset mid-SHIFT:** the enables drop in the next cycle. LFSR contents are a partial shift and are not restored; the bench must reload.
- The command is a registered output path: no combinational path from `cmd_valid_i` to any `*_ser_*` output.

## Test plan
- **Load W:** DataWidth = 32, target `01`, peek 0, seed `0xDEADBEEF`, LFSR prior state `0x12345678`.
  - Exactly 32 `w_ser_en_o` cycles.
  - `rsp_state_o` = `0x12345678`.
  - A subsequent peek of W returns `0xDEADBEEF`.
- **Peek R twice:** LFSR R state `0xA5A5_0F0F`.
  - Both responses = `0xA5A50F0F`.
  - AXI R data after the peeks is unchanged from before.
- **RWAIT:** target `10`, `r_ready_i` held 0 for 10 cycles then 1.
  - `r_ser_en_o` stays 0 while `r_valid` is pending.
  - It rises exactly 1 cycle after `r_ready_i` = 1.
  - No `r_valid` drop without a handshake.
- **Both sides:** target `11`, seed `0x0000_0001`.
  - Both enables are cycle-aligned.
  - Afterwards both LFSRs read `0x00000001`.
  - `rsp_state_o` = old W state.
- **Response back-pressure:** `rsp_ready_i` held 0 for 20 cycles.
  - `rsp_valid_o` and `rsp_state_o` stay stable.
  - `cmd_ready_o` stays 0.
  - A new command is accepted only after the handshake.
- **Reset at shift cycle 7:** all enables are 0 in the next cycle and outputs return to reset values; then a new load of `0xCAFEF00D` completes correctly.
